// File: rtl/vx_cluster_mem_arb_pkg.sv
// Shared width helpers for the cluster memory arbiter.
// Cluster-index widths are derived here so every file agrees on the tag layout.
package vx_cluster_mem_arb_pkg;

    // Number of tag bits used for the cluster index (0 when there is a single cluster).
    function automatic int log_nc(input int num_clusters);
        return (num_clusters > 1) ? $clog2(num_clusters) : 0;
    endfunction

    function automatic int tag_out_width(input int tag_in_width, input int num_clusters);
        return tag_in_width + log_nc(num_clusters);
    endfunction

    // A cluster-select register still needs one bit when log_nc is zero.
    function automatic int sel_width(input int num_clusters);
        return (num_clusters > 1) ? $clog2(num_clusters) : 1;
    endfunction

endpackage

// File: rtl/vx_cluster_mem_arb_elastic_buffer.sv
// Small synchronous FIFO holding arbitrated memory requests.
// Pop may free a slot in the same cycle as a push when full.
module vx_cluster_mem_arb_elastic_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE       = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  full,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  not_empty
);

    localparam int PTR_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int CNT_W = $clog2(SIZE + 1);

    logic [DATA_WIDTH-1:0] mem [SIZE];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  do_push;
    logic                  do_pop;

    assign full      = (count == CNT_W'(SIZE));
    assign not_empty = (count != '0);
    assign do_pop    = pop & not_empty;
    assign do_push   = push & (~full | do_pop);
    assign data_out  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (int'(wr_ptr) == SIZE - 1) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (int'(rd_ptr) == SIZE - 1) ? '0 : rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    // NOTE: storage is not reset; only the pointers/count decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/vx_cluster_mem_arb.sv
// Round-robin arbiter merging cluster memory ports onto one memory port,
// with tag-based routing of responses back to the originating cluster.
module vx_cluster_mem_arb
    import vx_cluster_mem_arb_pkg::*;
#(
    parameter  int NUM_CLUSTERS  = 2,
    parameter  int DATA_WIDTH    = 512,
    parameter  int ADDR_WIDTH    = 26,
    parameter  int TAG_IN_WIDTH  = 8,
    localparam int BYTEEN_WIDTH  = DATA_WIDTH / 8,
    localparam int LOG_NC        = log_nc(NUM_CLUSTERS),
    localparam int TAG_OUT_WIDTH = tag_out_width(TAG_IN_WIDTH, NUM_CLUSTERS)
) (
    input  logic                                       clk,
    input  logic                                       reset,

    input  logic [NUM_CLUSTERS-1:0]                    req_valid_in,
    input  logic [NUM_CLUSTERS-1:0]                    req_rw_in,
    input  logic [NUM_CLUSTERS-1:0][BYTEEN_WIDTH-1:0]  req_byteen_in,
    input  logic [NUM_CLUSTERS-1:0][ADDR_WIDTH-1:0]    req_addr_in,
    input  logic [NUM_CLUSTERS-1:0][DATA_WIDTH-1:0]    req_data_in,
    input  logic [NUM_CLUSTERS-1:0][TAG_IN_WIDTH-1:0]  req_tag_in,
    output logic [NUM_CLUSTERS-1:0]                    req_ready_in,

    output logic                                       req_valid_out,
    output logic                                       req_rw_out,
    output logic [BYTEEN_WIDTH-1:0]                    req_byteen_out,
    output logic [ADDR_WIDTH-1:0]                      req_addr_out,
    output logic [DATA_WIDTH-1:0]                      req_data_out,
    output logic [TAG_OUT_WIDTH-1:0]                   req_tag_out,
    input  logic                                       req_ready_out,

    input  logic                                       rsp_valid_in,
    input  logic [DATA_WIDTH-1:0]                      rsp_data_in,
    input  logic [TAG_OUT_WIDTH-1:0]                   rsp_tag_in,
    output logic                                       rsp_ready_in,

    output logic [NUM_CLUSTERS-1:0]                    rsp_valid_out,
    output logic [NUM_CLUSTERS-1:0][DATA_WIDTH-1:0]    rsp_data_out,
    output logic [NUM_CLUSTERS-1:0][TAG_IN_WIDTH-1:0]  rsp_tag_out,
    input  logic [NUM_CLUSTERS-1:0]                    rsp_ready_out,

    output logic                                       busy
);

    localparam int SEL_W = sel_width(NUM_CLUSTERS);
    localparam int REQ_W = 1 + BYTEEN_WIDTH + ADDR_WIDTH + DATA_WIDTH + TAG_OUT_WIDTH;

    // ---------------- request path ----------------
    logic [SEL_W-1:0]         rr_ptr;
    logic [SEL_W-1:0]         grant_idx;
    logic                     grant_vld;
    logic                     req_accept;
    logic [TAG_OUT_WIDTH-1:0] grant_tag;
    logic [REQ_W-1:0]         fifo_din;
    logic [REQ_W-1:0]         fifo_dout;
    logic                     fifo_full;
    logic                     fifo_not_empty;

    // NOTE: every always_comb output gets a default before the loop so no latch is inferred.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < NUM_CLUSTERS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CLUSTERS) idx -= NUM_CLUSTERS;
            if (!grant_vld && req_valid_in[idx]) begin
                grant_vld = 1'b1;
                grant_idx = SEL_W'(idx);
            end
        end
    end

    // Readiness looks only at the registered FIFO state, never at req_ready_out.
    assign req_accept = reset & grant_vld & ~fifo_full;

    for (genvar i = 0; i < NUM_CLUSTERS; i++) begin : g_req_ready
        assign req_ready_in[i] = req_accept & (grant_idx == SEL_W'(i));
    end

    if (LOG_NC == 0) begin : g_tag_single
        assign grant_tag = req_tag_in[grant_idx];
    end else begin : g_tag_multi
        assign grant_tag = {req_tag_in[grant_idx], grant_idx};
    end

    assign fifo_din = {req_rw_in[grant_idx], req_byteen_in[grant_idx], req_addr_in[grant_idx],
                       req_data_in[grant_idx], grant_tag};

    vx_cluster_mem_arb_elastic_buffer #(
        .DATA_WIDTH (REQ_W),
        .SIZE       (2)
    ) req_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req_accept),
        .data_in   (fifo_din),
        .full      (fifo_full),
        .pop       (req_valid_out & req_ready_out),
        .data_out  (fifo_dout),
        .not_empty (fifo_not_empty)
    );

    assign req_valid_out = reset & fifo_not_empty;
    assign {req_rw_out, req_byteen_out, req_addr_out, req_data_out, req_tag_out} = fifo_dout;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (req_accept) begin
            rr_ptr <= (int'(grant_idx) == NUM_CLUSTERS - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    // ---------------- response path ----------------
    logic                    rsp_vld_r;
    logic [SEL_W-1:0]        rsp_sel_r;
    logic [DATA_WIDTH-1:0]   rsp_data_r;
    logic [TAG_IN_WIDTH-1:0] rsp_tag_r;
    logic [SEL_W-1:0]        rsp_sel;
    logic                    rsp_legal;
    logic                    rsp_fire;
    logic                    rsp_pop;

    if (LOG_NC == 0) begin : g_sel_single
        assign rsp_sel = '0;
    end else begin : g_sel_multi
        assign rsp_sel = rsp_tag_in[LOG_NC-1:0];
    end

    assign rsp_legal    = (int'(rsp_sel) < NUM_CLUSTERS);
    assign rsp_pop      = rsp_vld_r & rsp_ready_out[rsp_sel_r];
    assign rsp_ready_in = reset & (~rsp_vld_r | rsp_ready_out[rsp_sel_r]);
    assign rsp_fire     = rsp_valid_in & rsp_ready_in;

    // An illegal response is consumed but never loaded, so the register empties.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_vld_r <= 1'b0;
        end else if (rsp_fire) begin
            rsp_vld_r <= rsp_legal;
        end else if (rsp_pop) begin
            rsp_vld_r <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_fire && rsp_legal) begin
            rsp_data_r <= rsp_data_in;
            rsp_tag_r  <= rsp_tag_in[TAG_OUT_WIDTH-1:LOG_NC];
            rsp_sel_r  <= rsp_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && rsp_fire) assert (rsp_legal);
    end

    for (genvar i = 0; i < NUM_CLUSTERS; i++) begin : g_rsp_out
        assign rsp_valid_out[i] = reset & rsp_vld_r & (rsp_sel_r == SEL_W'(i));
        assign rsp_data_out[i]  = rsp_data_r;
        assign rsp_tag_out[i]   = rsp_tag_r;
    end

    assign busy = reset & (fifo_not_empty | rsp_vld_r);

endmodule

// File: tb/tb_vx_cluster_mem_arb.sv
// Directed scenarios for vx_cluster_mem_arb with a queue-based scoreboard
// on both the request and response paths (4 clusters, 8-bit tags).
module tb_vx_cluster_mem_arb;

    localparam int NC  = 4;
    localparam int DW  = 32;
    localparam int AW  = 26;
    localparam int TW  = 8;
    localparam int BW  = DW / 8;
    localparam int TOW = TW + 2;
    localparam int RW  = 1 + BW + AW + DW + TOW;

    typedef struct {
        logic           rw;
        logic [BW-1:0]  be;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
        logic [TOW-1:0] tag;
    } req_t;

    typedef struct {
        int            idx;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic reset;

    logic [NC-1:0]         req_valid_in;
    logic [NC-1:0]         req_rw_in;
    logic [NC-1:0][BW-1:0] req_byteen_in;
    logic [NC-1:0][AW-1:0] req_addr_in;
    logic [NC-1:0][DW-1:0] req_data_in;
    logic [NC-1:0][TW-1:0] req_tag_in;
    logic [NC-1:0]         req_ready_in;

    logic                  req_valid_out;
    logic                  req_rw_out;
    logic [BW-1:0]         req_byteen_out;
    logic [AW-1:0]         req_addr_out;
    logic [DW-1:0]         req_data_out;
    logic [TOW-1:0]        req_tag_out;
    logic                  req_ready_out;

    logic                  rsp_valid_in;
    logic [DW-1:0]         rsp_data_in;
    logic [TOW-1:0]        rsp_tag_in;
    logic                  rsp_ready_in;

    logic [NC-1:0]         rsp_valid_out;
    logic [NC-1:0][DW-1:0] rsp_data_out;
    logic [NC-1:0][TW-1:0] rsp_tag_out;
    logic [NC-1:0]         rsp_ready_out;

    logic                  busy;

    int   checks = 0;
    int   errors = 0;
    req_t req_q[$];
    rsp_t rsp_q[$];
    int   acc_q[$];

    logic          hold_prev = 1'b0;
    logic [RW-1:0] held_payload;

    vx_cluster_mem_arb #(
        .NUM_CLUSTERS (NC),
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .TAG_IN_WIDTH (TW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_in   (req_valid_in),
        .req_rw_in      (req_rw_in),
        .req_byteen_in  (req_byteen_in),
        .req_addr_in    (req_addr_in),
        .req_data_in    (req_data_in),
        .req_tag_in     (req_tag_in),
        .req_ready_in   (req_ready_in),
        .req_valid_out  (req_valid_out),
        .req_rw_out     (req_rw_out),
        .req_byteen_out (req_byteen_out),
        .req_addr_out   (req_addr_out),
        .req_data_out   (req_data_out),
        .req_tag_out    (req_tag_out),
        .req_ready_out  (req_ready_out),
        .rsp_valid_in   (rsp_valid_in),
        .rsp_data_in    (rsp_data_in),
        .rsp_tag_in     (rsp_tag_in),
        .rsp_ready_in   (rsp_ready_in),
        .rsp_valid_out  (rsp_valid_out),
        .rsp_data_out   (rsp_data_out),
        .rsp_tag_out    (rsp_tag_out),
        .rsp_ready_out  (rsp_ready_out),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    // Scoreboard monitor: records accepted transfers and checks every delivered one.
    always @(negedge clk) begin
        int   n_rdy;
        req_t r;
        rsp_t s;
        n_rdy = 0;
        for (int i = 0; i < NC; i++) begin
            if (req_ready_in[i] === 1'b1) n_rdy++;
            if (req_valid_in[i] && req_ready_in[i]) begin
                r.rw   = req_rw_in[i];
                r.be   = req_byteen_in[i];
                r.addr = req_addr_in[i];
                r.data = req_data_in[i];
                r.tag  = {req_tag_in[i], 2'(i)};
                req_q.push_back(r);
                acc_q.push_back(i);
            end
        end
        checks++;
        if (n_rdy > 1) begin
            errors++;
            $display("FAIL ready_onehot: got %0d req_ready_in high, expected at most 1", n_rdy);
        end

        if (hold_prev && reset) begin
            checks++;
            if (req_valid_out !== 1'b1 ||
                {req_rw_out, req_byteen_out, req_addr_out, req_data_out, req_tag_out} !== held_payload) begin
                errors++;
                $display("FAIL req_stable: got valid=%b payload=%h, expected valid=1 payload=%h",
                         req_valid_out, {req_rw_out, req_byteen_out, req_addr_out, req_data_out, req_tag_out},
                         held_payload);
            end
        end
        hold_prev    = reset && req_valid_out && !req_ready_out;
        held_payload = {req_rw_out, req_byteen_out, req_addr_out, req_data_out, req_tag_out};

        if (req_valid_out && req_ready_out) begin
            checks++;
            if (req_q.size() == 0) begin
                errors++;
                $display("FAIL req_unexpected: got tag %h with no request outstanding", req_tag_out);
            end else begin
                r = req_q.pop_front();
                if ({req_rw_out, req_byteen_out, req_addr_out, req_data_out, req_tag_out} !==
                    {r.rw, r.be, r.addr, r.data, r.tag}) begin
                    errors++;
                    $display("FAIL req_payload: got %h, expected %h",
                             {req_rw_out, req_byteen_out, req_addr_out, req_data_out, req_tag_out},
                             {r.rw, r.be, r.addr, r.data, r.tag});
                end
            end
        end

        if (rsp_valid_in && rsp_ready_in) begin
            s.idx  = int'(rsp_tag_in[1:0]);
            s.tag  = rsp_tag_in[TOW-1:2];
            s.data = rsp_data_in;
            rsp_q.push_back(s);
        end
        for (int i = 0; i < NC; i++) begin
            if (rsp_valid_out[i] && rsp_ready_out[i]) begin
                checks++;
                if (rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got response on cluster %0d with none outstanding", i);
                end else begin
                    s = rsp_q.pop_front();
                    if (i != s.idx || rsp_tag_out[i] !== s.tag || rsp_data_out[i] !== s.data) begin
                        errors++;
                        $display("FAIL rsp_payload: got cluster %0d tag %h data %h, expected cluster %0d tag %h data %h",
                                 i, rsp_tag_out[i], rsp_data_out[i], s.idx, s.tag, s.data);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid_in  = '0;
        req_rw_in     = '0;
        req_byteen_in = '0;
        req_addr_in   = '0;
        req_data_in   = '0;
        req_tag_in    = '0;
        req_ready_out = 1'b0;
        rsp_valid_in  = 1'b0;
        rsp_data_in   = '0;
        rsp_tag_in    = '0;
        rsp_ready_out = '0;
    endtask

    task automatic set_cluster(input int i, input logic [TW-1:0] tag);
        req_rw_in[i]     = tag[0];
        req_byteen_in[i] = tag[3:0] ^ 4'hF;
        req_addr_in[i]   = 26'h0100_000 + AW'(tag);
        req_data_in[i]   = 32'hA5A5_0000 | DW'(tag);
        req_tag_in[i]    = tag;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_valid_out !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b, expected 0", req_valid_out); end
        checks++;
        if (rsp_valid_out !== '0) begin errors++; $display("FAIL reset_rsp_valid: got %b, expected 0", rsp_valid_out); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++;
        if (req_ready_in !== '0) begin errors++; $display("FAIL reset_req_ready: got %b, expected 0", req_ready_in); end
        checks++;
        if (rsp_ready_in !== 1'b0) begin errors++; $display("FAIL reset_rsp_ready: got %b, expected 0", rsp_ready_in); end
        step();
        reset = 1'b1;
    endtask

    task automatic test_fairness();
        acc_q.delete();
        req_ready_out = 1'b1;
        for (int i = 0; i < NC; i++) set_cluster(i, 8'h10 + 8'(i));
        req_valid_in = '1;
        repeat (12) step();
        req_valid_in = '0;
        repeat (4) step();
        checks++;
        if (acc_q.size() != 12) begin
            errors++;
            $display("FAIL fair_count: got %0d grants, expected 12", acc_q.size());
        end
        for (int k = 0; k < acc_q.size() && k < 12; k++) begin
            checks++;
            if (acc_q[k] != k % NC) begin
                errors++;
                $display("FAIL fair_order: grant %0d got cluster %0d, expected %0d", k, acc_q[k], k % NC);
            end
        end
        checks++;
        if (req_q.size() != 0) begin errors++; $display("FAIL fair_drain: got %0d left, expected 0", req_q.size()); end
    endtask

    task automatic test_tag();
        set_cluster(2, 8'h5A);
        req_valid_in  = 4'b0100;
        req_ready_out = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready_in !== 4'b0100) begin errors++; $display("FAIL tag_grant: got %b, expected 0100", req_ready_in); end
        checks++;
        if (req_valid_out !== 1'b0) begin errors++; $display("FAIL tag_latency: got valid %b same cycle, expected 0", req_valid_out); end
        step();
        req_valid_in = '0;
        @(negedge clk);
        checks++;
        if (req_valid_out !== 1'b1 || req_tag_out !== 10'h16A) begin
            errors++;
            $display("FAIL tag_out: got valid %b tag %h, expected valid 1 tag 16a", req_valid_out, req_tag_out);
        end
        step();
    endtask

    task automatic test_backpressure();
        acc_q.delete();
        req_ready_out = 1'b0;
        for (int i = 0; i < NC; i++) set_cluster(i, 8'h20 + 8'(i));
        req_valid_in = '1;
        repeat (5) step();
        @(negedge clk);
        checks++;
        if (req_ready_in !== '0) begin errors++; $display("FAIL bp_ready: got %b, expected 0000", req_ready_in); end
        checks++;
        if (acc_q.size() != 2) begin
            errors++;
            $display("FAIL bp_count: got %0d accepted, expected 2", acc_q.size());
        end else begin
            checks++;
            if (acc_q[0] != 3 || acc_q[1] != 0) begin
                errors++;
                $display("FAIL bp_order: got %0d,%0d, expected 3,0", acc_q[0], acc_q[1]);
            end
        end
        step();
        req_valid_in  = '0;
        req_ready_out = 1'b1;
        repeat (3) step();
        checks++;
        if (req_q.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d left, expected 0", req_q.size()); end
    endtask

    task automatic test_response();
        rsp_ready_out = '0;
        rsp_data_in   = 32'hCAFE_0001;
        rsp_tag_in    = 10'h16A;
        rsp_valid_in  = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_ready_in !== 1'b1 || rsp_valid_out !== '0) begin
            errors++;
            $display("FAIL rsp_accept: got ready %b valid %b, expected ready 1 valid 0000", rsp_ready_in, rsp_valid_out);
        end
        step();
        rsp_tag_in  = 10'h0C1;
        rsp_data_in = 32'hCAFE_0002;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid_out !== 4'b0100 || rsp_tag_out[2] !== 8'h5A ||
                rsp_data_out[2] !== 32'hCAFE_0001 || rsp_ready_in !== 1'b0) begin
                errors++;
                $display("FAIL rsp_hold: cycle %0d got valid %b tag %h data %h ready %b, expected 0100 5a cafe0001 0",
                         c, rsp_valid_out, rsp_tag_out[2], rsp_data_out[2], rsp_ready_in);
            end
            step();
        end
        rsp_ready_out = 4'b0100;
        @(negedge clk);
        checks++;
        if (rsp_ready_in !== 1'b1) begin errors++; $display("FAIL rsp_release: got ready %b, expected 1", rsp_ready_in); end
        step();
        rsp_valid_in  = 1'b0;
        rsp_ready_out = '1;
        @(negedge clk);
        checks++;
        if (rsp_valid_out !== 4'b0010 || rsp_tag_out[1] !== 8'h30) begin
            errors++;
            $display("FAIL rsp_second: got valid %b tag %h, expected 0010 30", rsp_valid_out, rsp_tag_out[1]);
        end
        repeat (2) step();
        checks++;
        if (rsp_q.size() != 0) begin errors++; $display("FAIL rsp_drain: got %0d left, expected 0", rsp_q.size()); end
    endtask

    task automatic test_concurrency();
        req_ready_out = 1'b0;
        rsp_ready_out = '0;
        set_cluster(1, 8'h77);
        req_valid_in = 4'b0010;
        rsp_valid_in = 1'b1;
        rsp_tag_in   = 10'h003;
        rsp_data_in  = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (req_ready_in !== 4'b0010 || rsp_ready_in !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL conc_accept: got req_ready %b rsp_ready %b busy %b, expected 0010 1 0",
                     req_ready_in, rsp_ready_in, busy);
        end
        step();
        req_valid_in = '0;
        rsp_valid_in = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || req_valid_out !== 1'b1 || rsp_valid_out !== 4'b1000) begin
                errors++;
                $display("FAIL conc_held: got busy %b req_valid %b rsp_valid %b, expected 1 1 1000",
                         busy, req_valid_out, rsp_valid_out);
            end
            step();
        end
        req_ready_out = 1'b1;
        rsp_ready_out = '1;
        step();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL conc_idle: got busy %b, expected 0", busy); end
        checks++;
        if (req_q.size() != 0 || rsp_q.size() != 0) begin
            errors++;
            $display("FAIL conc_drain: got %0d/%0d left, expected 0/0", req_q.size(), rsp_q.size());
        end
        step();
    endtask

    task automatic test_reset_mid();
        req_ready_out = 1'b0;
        rsp_ready_out = '0;
        set_cluster(1, 8'h31);
        set_cluster(2, 8'h32);
        req_valid_in = 4'b0110;
        rsp_valid_in = 1'b1;
        rsp_tag_in   = 10'h042;
        rsp_data_in  = 32'hDEAD_BEEF;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if (req_ready_in !== '0 || busy !== 1'b1 || req_valid_out !== 1'b1 || rsp_valid_out !== 4'b0100) begin
            errors++;
            $display("FAIL mid_fill: got ready %b busy %b req_valid %b rsp_valid %b, expected 0000 1 1 0100",
                     req_ready_in, busy, req_valid_out, rsp_valid_out);
        end
        step();
        reset        = 1'b0;
        req_valid_in = '0;
        rsp_valid_in = 1'b0;
        step();
        req_q.delete();
        rsp_q.delete();
        acc_q.delete();
        @(negedge clk);
        checks++;
        if (req_valid_out !== 1'b0 || rsp_valid_out !== '0 || busy !== 1'b0 ||
            req_ready_in !== '0 || rsp_ready_in !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got req_valid %b rsp_valid %b busy %b req_ready %b rsp_ready %b, expected all 0",
                     req_valid_out, rsp_valid_out, busy, req_ready_in, rsp_ready_in);
        end
        step();
        reset         = 1'b1;
        req_ready_out = 1'b1;
        rsp_ready_out = '1;
        for (int i = 0; i < NC; i++) set_cluster(i, 8'h40 + 8'(i));
        req_valid_in = '1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req_valid_out !== 1'b0 || req_ready_in !== 4'b0001) begin
            errors++;
            $display("FAIL mid_restart: got busy %b req_valid %b ready %b, expected 0 0 0001",
                     busy, req_valid_out, req_ready_in);
        end
        repeat (2) step();
        req_valid_in = '0;
        repeat (3) step();
        checks++;
        if (acc_q.size() != 2 || req_q.size() != 0) begin
            errors++;
            $display("FAIL mid_after: got %0d grants %0d left, expected 2 grants 0 left", acc_q.size(), req_q.size());
        end else begin
            checks++;
            if (acc_q[0] != 0 || acc_q[1] != 1) begin
                errors++;
                $display("FAIL mid_order: got %0d,%0d, expected 0,1", acc_q[0], acc_q[1]);
            end
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_fairness();
        test_tag();
        test_backpressure();
        test_response();
        test_concurrency();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
